// File: rtl/data_cache_pkg.sv
`default_nettype none
// ============================================================================
// Package     : data_cache_pkg
// Description : Shared types and helpers for the data-cache miss sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package data_cache_pkg;

  localparam int DC_LINE_WORDS = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WB_REQ  = 3'd1,
    ST_WB_DATA = 3'd2,
    ST_RF_REQ  = 3'd3,
    ST_RF_DATA = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  function automatic int unsigned dc_idx_width(input int unsigned line_words);
    return $clog2(line_words);
  endfunction

  // Byte offset inside a line: word index plus two bits of byte-in-word.
  function automatic int unsigned dc_off_width(input int unsigned line_words);
    return $clog2(line_words) + 2;
  endfunction

  function automatic logic [63:0] dc_line_align(input logic [63:0] addr,
                                                input int unsigned off_w);
    return addr & ~((64'd1 << off_w) - 64'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_cache_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : data_cache_sat_counter
// Description : Event counter that sticks at all-ones instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module data_cache_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/data_cache_refill_controller.sv
`default_nettype none
// ============================================================================
// Module      : data_cache_refill_controller
// Description : Miss sequencer: optional dirty-victim write-back, then a line
//               refill streamed beat by beat into the cache array.
// Revision    : 1.0 - initial release
// ============================================================================
module data_cache_refill_controller
  import data_cache_pkg::*;
#(
  parameter  int ADDR_WIDTH = 32,
  parameter  int DATA_WIDTH = 32,
  parameter  int LINE_WORDS = DC_LINE_WORDS,
  localparam int IDX_W      = dc_idx_width(LINE_WORDS),
  localparam int OFF_W      = dc_off_width(LINE_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // cache array side
  input  logic                  miss_valid,
  input  logic [ADDR_WIDTH-1:0] miss_address,
  input  logic                  miss_dirty,
  input  logic [ADDR_WIDTH-1:0] victim_address,
  input  logic [DATA_WIDTH-1:0] victim_data,
  output logic [IDX_W-1:0]      victim_word_index,
  output logic                  refill_write_enable,
  output logic [IDX_W-1:0]      refill_word_index,
  output logic [DATA_WIDTH-1:0] refill_data,
  output logic                  refill_done,
  output logic                  cache_ready,
  // memory bus side
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_write,
  output logic [ADDR_WIDTH-1:0] mem_req_address,
  output logic                  mem_write_valid,
  input  logic                  mem_write_ready,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic                  mem_read_valid,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  // statistics
  output logic [31:0]           miss_count,
  output logic [31:0]           writeback_count
);

  state_t                  state_q;
  state_t                  state_d;
  logic [IDX_W-1:0]        beat_q;
  logic [IDX_W-1:0]        beat_d;
  logic [ADDR_WIDTH-1:0]   miss_line_q;
  logic [ADDR_WIDTH-1:0]   victim_line_q;
  logic [ADDR_WIDTH-1:0]   miss_line;
  logic [ADDR_WIDTH-1:0]   victim_line;
  logic                    miss_accept;
  logic                    wb_start;
  logic                    last_beat;

  assign miss_accept = (state_q == ST_IDLE) && miss_valid;
  assign wb_start    = miss_accept && miss_dirty;
  assign last_beat   = (beat_q == IDX_W'(LINE_WORDS - 1));

  assign miss_line   = ADDR_WIDTH'(dc_line_align(64'(miss_address), OFF_W));
  assign victim_line = ADDR_WIDTH'(dc_line_align(64'(victim_address), OFF_W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  // Both line addresses are captured at miss time so the cache may reuse its
  // lookup port while the bursts run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_line_q   <= '0;
      victim_line_q <= '0;
    end else if (miss_accept) begin
      miss_line_q   <= miss_line;
      victim_line_q <= victim_line;
    end
  end

  always_comb begin
    state_d             = state_q;
    beat_d              = beat_q;
    cache_ready         = 1'b0;
    victim_word_index   = '0;
    refill_write_enable = 1'b0;
    refill_word_index   = '0;
    refill_data         = '0;
    refill_done         = 1'b0;
    mem_req_valid       = 1'b0;
    mem_req_write       = 1'b0;
    mem_req_address     = '0;
    mem_write_valid     = 1'b0;
    mem_write_data      = '0;

    case (state_q)
      ST_IDLE: begin
        cache_ready = 1'b1;
        if (miss_valid) begin
          state_d = miss_dirty ? ST_WB_REQ : ST_RF_REQ;
        end
      end

      ST_WB_REQ: begin
        mem_req_valid   = 1'b1;
        mem_req_write   = 1'b1;
        mem_req_address = victim_line_q;
        if (mem_req_ready) begin
          state_d = ST_WB_DATA;
          beat_d  = '0;
        end
      end

      ST_WB_DATA: begin
        mem_write_valid   = 1'b1;
        victim_word_index = beat_q;
        mem_write_data    = victim_data;
        if (mem_write_ready) begin
          beat_d = beat_q + 1'b1;
          if (last_beat) begin
            state_d = ST_RF_REQ;
          end
        end
      end

      ST_RF_REQ: begin
        mem_req_valid   = 1'b1;
        mem_req_address = miss_line_q;
        if (mem_req_ready) begin
          state_d = ST_RF_DATA;
          beat_d  = '0;
        end
      end

      // Memory cannot be stalled, so each read beat is written straight through.
      ST_RF_DATA: begin
        if (mem_read_valid) begin
          refill_write_enable = 1'b1;
          refill_word_index   = beat_q;
          refill_data         = mem_read_data;
          beat_d              = beat_q + 1'b1;
          if (last_beat) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        refill_done = 1'b1;
        state_d     = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        beat_d  = '0;
      end
    endcase
  end

  data_cache_sat_counter #(
    .WIDTH (32)
  ) u_miss_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (miss_accept),
    .count (miss_count)
  );

  data_cache_sat_counter #(
    .WIDTH (32)
  ) u_writeback_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (wb_start),
    .count (writeback_count)
  );

endmodule
`default_nettype wire
